bit_stream_serializer: RTL and testbench

- Parallel-to-serial stage directly upstream of the Mealy sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock on ser_out, which drives the detector's data_in.
- A one-word holding register allows gapless back-to-back frames.
- When no word is available, it emits a constant idle fill bit.

---
 rtl/bit_stream_serializer_pkg.sv | 14 +
 rtl/bit_stream_serializer_if.sv | 17 +
 rtl/bit_stream_serializer_hold_reg.sv | 35 +++
 rtl/bit_stream_serializer.sv | 111 +++++++++++
 tb/tb_bit_stream_serializer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/bit_stream_serializer_pkg.sv
// Shared types and constants for the bit stream serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int FRAME_CNT_W   = 16;

endpackage

// File: rtl/bit_stream_serializer_if.sv
// Parallel word handshake into the serializer (valid/ready).
// Latency: n/a (wiring only).
// Backpressure: sink deasserts in_ready; source holds in_data while stalled.
interface bit_stream_serializer_if
    import serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/bit_stream_serializer_hold_reg.sv
// One-entry holding register that parks the next word while the shifter is busy.
// Latency: written word is visible on hold the cycle after wr.
// Backpressure: hold_full tells the owner to stop accepting words.
module ser_hold_reg
    import serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr,
    input  logic             rd_clr,
    input  logic [WIDTH-1:0] wr_dat,
    output logic [WIDTH-1:0] hold,
    output logic             hold_full
);

    // Abort clears the entry; a write in the same cycle as a read keeps it full.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (clr) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (wr) begin
            hold      <= wr_dat;
            hold_full <= 1'b1;
        end else if (rd_clr) begin
            hold_full <= 1'b0;
        end
    end

endmodule

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial stage: WIDTH-bit words out one bit per clock, idle fill otherwise.
// Latency: first bit one cycle after the accepting edge; a word spans WIDTH cycles.
// Backpressure: in_ready drops while the hold slot is full, in reset, or during flush.
module bit_stream_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    bit_stream_serializer_if.slave in_if,
    input  logic                   flush,
    output logic                   ser_out,
    output logic                   ser_active,
    output logic                   frame_last,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int             CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t                 state, state_nxt;
    logic [WIDTH-1:0]       sh, sh_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [FRAME_CNT_W-1:0] frame_count_q;
    logic [WIDTH-1:0]       hold;
    logic                   hold_full;
    logic                   hold_wr;
    logic                   hold_rd;
    logic                   xfer;
    logic                   last_bit;
    logic                   load_pt;

    assign in_if.in_ready = rst && !hold_full && !flush;
    assign xfer           = in_if.in_valid && in_if.in_ready;
    assign last_bit       = (state == ST_SHIFT) && (cnt == CNT_LAST);
    // A new word may enter the shifter when idle or as the last bit leaves.
    assign load_pt        = (state == ST_IDLE) || last_bit;

    ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .wr        (hold_wr),
        .rd_clr    (hold_rd),
        .wr_dat    (in_if.in_data),
        .hold      (hold),
        .hold_full (hold_full)
    );

    // State, shifter and bit index registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            sh    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sh    <= sh_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: flush abort, word load (hold first), or shift advance.
    always_comb begin
        state_nxt = state;
        sh_nxt    = sh;
        cnt_nxt   = cnt;
        hold_wr   = 1'b0;
        hold_rd   = 1'b0;
        if (flush) begin
            state_nxt = ST_IDLE;
            sh_nxt    = '0;
            cnt_nxt   = '0;
        end else if (load_pt) begin
            cnt_nxt = '0;
            if (hold_full) begin
                sh_nxt    = hold;
                hold_rd   = 1'b1;
                hold_wr   = xfer;
                state_nxt = ST_SHIFT;
            end else if (xfer) begin
                sh_nxt    = in_if.in_data;
                state_nxt = ST_SHIFT;
            end else begin
                state_nxt = ST_IDLE;
            end
        end else begin
            sh_nxt  = MSB_FIRST ? (sh << 1) : (sh >> 1);
            cnt_nxt = cnt + CNT_W'(1);
            hold_wr = xfer;
        end
    end

    // Completed-word counter; an aborted last bit does not count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_count_q <= '0;
        end else if (last_bit && !flush) begin
            frame_count_q <= frame_count_q + FRAME_CNT_W'(1);
        end
    end

    assign ser_out     = (state == ST_SHIFT) ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : IDLE_BIT;
    assign ser_active  = (state == ST_SHIFT);
    assign frame_last  = last_bit;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed bench for bit_stream_serializer (MSB-first WIDTH=8 and LSB-first WIDTH=4).
// Latency: outputs sampled on the falling edge, inputs driven there too.
// Backpressure: source model honours in_ready before advancing words.
module tb_bit_stream_serializer;
    import serializer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic flush;

    bit_stream_serializer_if #(.WIDTH(8)) m_if ();
    bit_stream_serializer_if #(.WIDTH(4)) l_if ();

    logic                   ser_out, ser_active, frame_last;
    logic [FRAME_CNT_W-1:0] frame_count;
    logic                   l_ser_out, l_ser_active, l_frame_last;
    logic [FRAME_CNT_W-1:0] l_frame_count;

    int n_cmp = 0;
    int n_err = 0;

    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk (clk), .rst (rst), .in_if (m_if), .flush (flush),
        .ser_out (ser_out), .ser_active (ser_active),
        .frame_last (frame_last), .frame_count (frame_count)
    );

    bit_stream_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk (clk), .rst (rst), .in_if (l_if), .flush (flush),
        .ser_out (l_ser_out), .ser_active (l_ser_active),
        .frame_last (l_frame_last), .frame_count (l_frame_count)
    );

    task automatic do_reset();
        rst = 1'b0; flush = 1'b0;
        m_if.in_valid = 1'b0; m_if.in_data = '0;
        l_if.in_valid = 1'b0; l_if.in_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0;
        m_if.in_valid = 1'b1; m_if.in_data = 8'hAA;
        l_if.in_valid = 1'b0; l_if.in_data = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (m_if.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", m_if.in_ready); end
        n_cmp++; if (ser_out !== 1'b0) begin n_err++; $display("FAIL reset_ser_out: got %b want 0", ser_out); end
        n_cmp++; if (ser_active !== 1'b0) begin n_err++; $display("FAIL reset_ser_active: got %b want 0", ser_active); end
        n_cmp++; if (frame_last !== 1'b0) begin n_err++; $display("FAIL reset_frame_last: got %b want 0", frame_last); end
        n_cmp++; if (frame_count !== 16'h0) begin n_err++; $display("FAIL reset_frame_count: got %h want 0000", frame_count); end
        n_cmp++; if (l_frame_count !== 16'h0) begin n_err++; $display("FAIL reset_lsb_frame_count: got %h want 0000", l_frame_count); end
        m_if.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (ser_active !== 1'b0) begin n_err++; $display("FAIL reset_no_xfer: got active %b want 0", ser_active); end
    endtask

    task automatic test_single();
        logic [7:0] w;
        w = 8'b11011000;
        do_reset();
        m_if.in_valid = 1'b1; m_if.in_data = w;
        #1;
        n_cmp++; if (m_if.in_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", m_if.in_ready); end
        @(negedge clk);
        m_if.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (ser_out !== w[7-i]) begin n_err++; $display("FAIL single_bit%0d: got %b want %b", i, ser_out, w[7-i]); end
            n_cmp++; if (ser_active !== 1'b1) begin n_err++; $display("FAIL single_active%0d: got %b want 1", i, ser_active); end
            n_cmp++; if (frame_last !== (i == 7)) begin n_err++; $display("FAIL single_last%0d: got %b want %b", i, frame_last, (i == 7)); end
            if (i == 7) begin
                n_cmp++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL single_count_early: got %0d want 0", frame_count); end
            end
            @(negedge clk);
        end
        n_cmp++; if (ser_out !== 1'b0) begin n_err++; $display("FAIL single_idle_out: got %b want 0", ser_out); end
        n_cmp++; if (ser_active !== 1'b0) begin n_err++; $display("FAIL single_idle_active: got %b want 0", ser_active); end
        n_cmp++; if (frame_last !== 1'b0) begin n_err++; $display("FAIL single_idle_last: got %b want 0", frame_last); end
        n_cmp++; if (frame_count !== 16'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", frame_count); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] stream;
        logic [7:0]  words [3];
        int          idx, pos, gaps;
        bit          seen, done, saw_nr, xf;
        stream = {8'hD8, 8'hFF, 8'h00};
        words[0] = 8'hD8; words[1] = 8'hFF; words[2] = 8'h00;
        idx = 0; pos = 0; gaps = 0; seen = 0; done = 0; saw_nr = 0;
        do_reset();
        m_if.in_valid = 1'b1; m_if.in_data = words[0];
        for (int cyc = 0; cyc < 34; cyc++) begin
            #1;
            if (m_if.in_valid && !m_if.in_ready) saw_nr = 1;
            xf = m_if.in_valid && m_if.in_ready;
            @(negedge clk);
            if (xf) begin
                idx++;
                if (idx == 3) m_if.in_valid = 1'b0;
                else m_if.in_data = words[idx];
            end
            if (ser_active) begin
                if (done) gaps++;
                seen = 1;
                if (pos < 24) begin
                    n_cmp++; if (ser_out !== stream[23-pos]) begin n_err++; $display("FAIL b2b_bit%0d: got %b want %b", pos, ser_out, stream[23-pos]); end
                end
                pos++;
            end else if (seen) begin
                done = 1;
            end
        end
        n_cmp++; if (pos !== 24) begin n_err++; $display("FAIL b2b_bit_count: got %0d want 24", pos); end
        n_cmp++; if (gaps !== 0) begin n_err++; $display("FAIL b2b_gaps: got %0d want 0", gaps); end
        n_cmp++; if (saw_nr !== 1'b1) begin n_err++; $display("FAIL b2b_backpressure: got %b want 1", saw_nr); end
        n_cmp++; if (frame_count !== 16'd3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", frame_count); end
        n_cmp++; if (ser_active !== 1'b0) begin n_err++; $display("FAIL b2b_end_idle: got %b want 0", ser_active); end
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({ser_out, ser_active, frame_last} !== 3'b000 || frame_count !== 16'd0) begin
                n_err++; $display("FAIL idle_cyc%0d: got out/act/last %b%b%b count %0d want 000 count 0", i, ser_out, ser_active, frame_last, frame_count);
            end
        end
    endtask

    task automatic test_flush();
        int act;
        // Runs straight after the back-to-back case, so three frames are already counted.
        m_if.in_valid = 1'b1; m_if.in_data = 8'hD8;
        @(negedge clk);
        m_if.in_data = 8'hFF;
        @(negedge clk);
        m_if.in_valid = 1'b0;
        #1;
        n_cmp++; if (m_if.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_hold_full: got ready %b want 0", m_if.in_ready); end
        @(negedge clk);
        n_cmp++; if (ser_out !== 1'b0 || ser_active !== 1'b1) begin n_err++; $display("FAIL flush_bit3: got out %b act %b want 0 1", ser_out, ser_active); end
        flush = 1'b1; m_if.in_valid = 1'b1; m_if.in_data = 8'h81;
        @(negedge clk);
        flush = 1'b0; m_if.in_valid = 1'b0;
        n_cmp++; if (ser_active !== 1'b0) begin n_err++; $display("FAIL flush_active: got %b want 0", ser_active); end
        n_cmp++; if (ser_out !== 1'b0) begin n_err++; $display("FAIL flush_out: got %b want 0", ser_out); end
        n_cmp++; if (frame_count !== 16'd3) begin n_err++; $display("FAIL flush_count: got %0d want 3", frame_count); end
        #1;
        n_cmp++; if (m_if.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready_after: got %b want 1", m_if.in_ready); end
        act = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ser_active) act++;
        end
        n_cmp++; if (act !== 0) begin n_err++; $display("FAIL flush_no_resume: got %0d active cycles want 0", act); end
        n_cmp++; if (frame_count !== 16'd3) begin n_err++; $display("FAIL flush_count_later: got %0d want 3", frame_count); end
    endtask

    task automatic test_reset_mid();
        int act;
        do_reset();
        m_if.in_valid = 1'b1; m_if.in_data = 8'hD8;
        @(negedge clk);
        m_if.in_data = 8'hFF;
        @(negedge clk);
        m_if.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (ser_out !== 1'b1 || ser_active !== 1'b1) begin n_err++; $display("FAIL rmid_bit4: got out %b act %b want 1 1", ser_out, ser_active); end
        rst = 1'b0; m_if.in_valid = 1'b1; m_if.in_data = 8'h5A;
        #1;
        n_cmp++; if (m_if.in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_ready_in_rst: got %b want 0", m_if.in_ready); end
        @(negedge clk);
        n_cmp++; if (ser_out !== 1'b0 || ser_active !== 1'b0 || frame_last !== 1'b0) begin n_err++; $display("FAIL rmid_idle: got out/act/last %b%b%b want 000", ser_out, ser_active, frame_last); end
        n_cmp++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL rmid_count: got %0d want 0", frame_count); end
        n_cmp++; if (m_if.in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_ready_still_rst: got %b want 0", m_if.in_ready); end
        m_if.in_valid = 1'b0; rst = 1'b1;
        #1;
        n_cmp++; if (m_if.in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_hold_empty: got ready %b want 1", m_if.in_ready); end
        act = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ser_active) act++;
        end
        n_cmp++; if (act !== 0) begin n_err++; $display("FAIL rmid_no_payload: got %0d active cycles want 0", act); end
        n_cmp++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL rmid_count_later: got %0d want 0", frame_count); end
    endtask

    task automatic test_lsb_wrap();
        logic [3:0] w;
        w = 4'b0011;
        do_reset();
        force dut_lsb.frame_count_q = 16'hFFFF;
        l_if.in_valid = 1'b1; l_if.in_data = w;
        @(negedge clk);
        release dut_lsb.frame_count_q;
        l_if.in_valid = 1'b0;
        n_cmp++; if (l_frame_count !== 16'hFFFF) begin n_err++; $display("FAIL lsb_preload: got %h want ffff", l_frame_count); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (l_ser_out !== w[i]) begin n_err++; $display("FAIL lsb_bit%0d: got %b want %b", i, l_ser_out, w[i]); end
            n_cmp++; if (l_ser_active !== 1'b1 || l_frame_last !== (i == 3)) begin n_err++; $display("FAIL lsb_flags%0d: got act %b last %b want 1 %b", i, l_ser_active, l_frame_last, (i == 3)); end
            @(negedge clk);
        end
        n_cmp++; if (l_ser_active !== 1'b0 || l_ser_out !== 1'b0) begin n_err++; $display("FAIL lsb_idle: got act %b out %b want 0 0", l_ser_active, l_ser_out); end
        n_cmp++; if (l_frame_count !== 16'h0000) begin n_err++; $display("FAIL lsb_wrap: got %h want 0000", l_frame_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_flush();
        test_idle();
        test_reset_mid();
        test_lsb_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
